inc_counter: RTL and testbench
==============================

# inc_counter

Parametrised loadable up/down counter that generalises the fixed 7-bit incrementer. Each enabled cycle it adds or subtracts a runtime step within a configurable range [0, MAX]. Out-of-range results either wrap or saturate. A terminal-count pulse and a sticky overflow flag are produced. It sits in the sequential-circuit library as the general counting primitive for timers, address generators and event counters.

## Interface

Parameters:
- WIDTH, 7, width of count, load and step buses
- MAX, 2**WIDTH-1, highest legal count value; must be ≥1 and ≤ 2**WIDTH-1
- PRESCALE, 4, enable divisor (only used with INC_PRESCALE_EN); must be ≥1

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- load  input  1  synchronous load of d
- d  input  WIDTH  load value
- en  input  1  count enable
- up  input  1  direction: 1 = add step, 0 = subtract step
- step  input  WIDTH  increment magnitude
- sat  input  1  range mode: 1 = saturate, 0 = wrap
- clr_ovf  input  1  synchronous clear of ovf
- q  output  WIDTH  current count
- tc  output  1  one-cycle terminal-count pulse
- ovf  output  1  sticky overflow flag

## Operation

- Priority on each rising edge is reset > load > en.
- **Load:** q <= min(d, MAX). Load clears tc and resets the prescaler. Load does not affect ovf.
- **Step clamp:** the effective step is s = min(step, MAX).
- **Step of zero:** q holds and tc is not asserted.
- **Up count:** the sum q+s is formed in WIDTH+1 bits.
  - If q+s ≤ MAX, then q <= q+s.
  - If q+s > MAX and sat=0, then q <= q+s-(MAX+1).
  - If q+s > MAX and sat=1, then q <= MAX.
- **Down count:**
  - If s ≤ q, then q <= q-s.
  - If s > q and sat=0, then q <= q+(MAX+1)-s.
  - If s > q and sat=1, then q <= 0.
- **Boundary event:** any enabled update whose unbounded result leaves [0, MAX], whether it wraps or clamps. This includes a repeated clamp while already sitting at a limit.
  - tc <= 1 for exactly the cycle following the event. Otherwise tc <= 0.
  - ovf <= 1 on an event. ovf <= 0 on clr_ovf. If set and clr_ovf occur in the same cycle, set wins.
- When en=0 and load=0, q holds and tc <= 0.
- Changing up, step or sat takes effect on the next enabled edge; there is no internal state tied to direction.

## Timing

- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency is 1 cycle: q, tc and ovf reflect the inputs sampled at the preceding rising edge.
- Reset values: q=0, tc=0, ovf=0, internal prescaler=0.
- Reset asserted at any time, including mid-count or mid-prescale, forces these values immediately, without waiting for a clock edge.
- Release of reset is synchronous in effect: the first update happens on the first rising edge after reset falls.
- With the prescaler compiled in, a load and an en in the same cycle perform the load only, and the prescaler restarts at 0.

## Configuration

- Macro: INC_PRESCALE_EN.
- **Defined:**
  - An internal counter ps (0..PRESCALE-1) advances on each cycle with en=1 and load=0.
  - The count update occurs only on an en cycle where ps==PRESCALE-1; ps then wraps to 0.
  - ps holds while en=0.
  - With PRESCALE=1 the behaviour is identical to the macro being undefined.
- **Undefined:**
  - Every en cycle performs an update.
  - No ps register exists, and the PRESCALE parameter is ignored.

## Test plan

Use WIDTH=7 and MAX=99 unless stated otherwise.

1. **Async reset:** count to q=42, then raise reset midway between edges → q=0, tc=0 and ovf=0 before the next edge; they stay there while reset=1.
2. **Load then count:** load=1 with d=7'b0000010, then en=1, up=1, step=1 → q=2, 3, 4 on successive edges; tc=0 throughout.
3. **Wrap:** load 98, then en=1, up=1, step=3, sat=0 → q=1, tc=1 for one cycle, ovf=1. The next step gives q=4, tc=0, ovf still 1.
4. **Saturate down:** load 5, then up=0, step=7, sat=1 → q=0 with tc=1. The next edge gives q=0 and tc=1 again (repeated clamp). Then assert clr_ovf with en=0 → ovf=0. Then assert clr_ovf together with a clamp event → ovf=1.
5. **Load clamp and priority:** load=1 with d=120 and en=1 in the same cycle → q=99 (load wins, clamped). Next, step=127 with up=1, sat=1 → q=99, tc=1.
6. **Prescale (macro defined, PRESCALE=4):** from q=0, en=1, step=1 → q=1 after 4 edges and 2 after 8. Build without the macro → q=1 after 1 edge.

Source files
------------

// File: rtl/inc_counter.sv
// Loadable up/down counter over the range [0, MAX]. Out-of-range results wrap or saturate.
// Compile-time option INC_PRESCALE_EN divides the count enable by PRESCALE.
module inc_counter #(
  parameter int WIDTH    = 7,
  parameter int MAX      = 2**WIDTH-1,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (MAX < 1 || MAX > 2**WIDTH-1) begin : g_bad_max
    $error("inc_counter: MAX must lie in [1, 2**WIDTH-1]");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("inc_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);
  localparam logic [WIDTH:0]   MAX_E = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   RANGE = MAX_E + 1'b1;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] d_clamp;
  logic [WIDTH:0]   s_e;
  logic [WIDTH:0]   q_e;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;
  logic             bnd;
  logic             ps_last;
  logic             upd;

  assign s       = (step > MAX_Q) ? MAX_Q : step;
  assign d_clamp = (d > MAX_Q) ? MAX_Q : d;
  assign s_e     = {1'b0, s};
  assign q_e     = {1'b0, q};

  // Up-sum is formed one bit wider so the carry is visible to the range test.
  always_comb begin
    sum = '0;
    nxt = q;
    bnd = 1'b0;
    if (up) begin
      sum = q_e + s_e;
      if (sum > MAX_E) begin
        bnd = 1'b1;
        nxt = sat ? MAX_Q : WIDTH'(sum - RANGE);
      end else begin
        nxt = sum[WIDTH-1:0];
      end
    end else if (s > q) begin
      bnd = 1'b1;
      nxt = sat ? '0 : WIDTH'(q_e + RANGE - s_e);
    end else begin
      nxt = q - s;
    end
  end

`ifdef INC_PRESCALE_EN
  localparam int                PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(PRESCALE-1);

  logic [PS_W-1:0] ps;

  assign ps_last = (ps == PS_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps <= '0;
    end else if (load) begin
      ps <= '0;
    end else if (en) begin
      ps <= ps_last ? '0 : ps + 1'b1;
    end
  end
`else
  assign ps_last = 1'b1;
`endif

  assign upd = en && !load && ps_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q   <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (load) begin
        q  <= d_clamp;
        tc <= 1'b0;
      end else if (upd) begin
        q  <= nxt;
        tc <= bnd;
      end else begin
        tc <= 1'b0;
      end

      if (upd && bnd) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inc_counter.sv
// Self-checking bench for inc_counter (WIDTH=7, MAX=99): directed vector table,
// async-reset and prescale sequences, then random stimulus against an integer model.
module tb_inc_counter;

  localparam int WIDTH    = 7;
  localparam int MAX      = 99;
  localparam int PRESCALE = 4;
`ifdef INC_PRESCALE_EN
  localparam int PS = PRESCALE;
`else
  localparam int PS = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] step;
  logic             sat;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  inc_counter #(.WIDTH(WIDTH), .MAX(MAX), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .reset(reset), .load(load), .d(d), .en(en), .up(up),
    .step(step), .sat(sat), .clr_ovf(clr_ovf), .q(q), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state kept as plain integers
  int mq, mtc, movf, mps;

  typedef struct {
    int ld, dv, e, u, st, sa, cl;
    int eq, etc, eo;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string name, input int eq, input int etc, input int eo);
    check({name, ".q"}, int'(q), eq);
    check({name, ".tc"}, int'(tc), etc);
    check({name, ".ovf"}, int'(ovf), eo);
  endtask

  function automatic void model_reset();
    mq = 0; mtc = 0; movf = 0; mps = 0;
  endfunction

  // Unbounded signed result, then wrap with modulo or clamp to the range ends.
  function automatic void model_step();
    int s, r, m;
    bit ev;
    ev = 0;
    m  = MAX + 1;
    if (load) begin
      mq  = (int'(d) > MAX) ? MAX : int'(d);
      mtc = 0;
      mps = 0;
    end else if (en) begin
      if (mps == PS - 1) begin
        mps = 0;
        s = (int'(step) > MAX) ? MAX : int'(step);
        r = up ? mq + s : mq - s;
        ev = (r > MAX) || (r < 0);
        if (!ev)      mq = r;
        else if (sat) mq = (r < 0) ? 0 : MAX;
        else          mq = ((r % m) + m) % m;
      end else begin
        mps = mps + 1;
      end
      mtc = ev;
    end else begin
      mtc = 0;
    end
    if (ev)           movf = 1;
    else if (clr_ovf) movf = 0;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int ld, input int dv, input int e, input int u,
                        input int st, input int sa, input int cl);
    load = ld[0]; d = dv[WIDTH-1:0]; en = e[0]; up = u[0];
    step = st[WIDTH-1:0]; sat = sa[0]; clr_ovf = cl[0];
  endtask

  initial begin
    set_in(0, 0, 0, 1, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0);
    reset = 1'b0;

`ifndef INC_PRESCALE_EN
    //           ld  d   en up st  sat clr   q  tc ovf
    tv.push_back('{1, 2,   0, 0, 0,   0, 0,  2, 0, 0});
    tv.push_back('{0, 0,   1, 1, 1,   0, 0,  3, 0, 0});
    tv.push_back('{0, 0,   1, 1, 1,   0, 0,  4, 0, 0});
    tv.push_back('{1, 98,  0, 0, 0,   0, 0, 98, 0, 0});
    tv.push_back('{0, 0,   1, 1, 3,   0, 0,  1, 1, 1});
    tv.push_back('{0, 0,   1, 1, 3,   0, 0,  4, 0, 1});
    tv.push_back('{1, 5,   0, 0, 0,   0, 0,  5, 0, 1});
    tv.push_back('{0, 0,   1, 0, 7,   1, 0,  0, 1, 1});
    tv.push_back('{0, 0,   1, 0, 7,   1, 0,  0, 1, 1});
    tv.push_back('{0, 0,   0, 0, 7,   1, 1,  0, 0, 0});
    tv.push_back('{0, 0,   1, 0, 7,   1, 1,  0, 1, 1});
    tv.push_back('{1, 120, 1, 1, 1,   0, 0, 99, 0, 1});
    tv.push_back('{0, 0,   1, 1, 127, 1, 0, 99, 1, 1});
    tv.push_back('{0, 0,   1, 1, 0,   0, 0, 99, 0, 1});
    tv.push_back('{0, 0,   0, 0, 0,   0, 1, 99, 0, 0});
    tv.push_back('{0, 0,   1, 0, 127, 0, 0,  0, 0, 0});
    tv.push_back('{0, 0,   1, 0, 1,   0, 0, 99, 1, 1});
    tv.push_back('{0, 0,   0, 0, 0,   0, 0, 99, 0, 1});
    tv.push_back('{0, 0,   1, 1, 1,   0, 0,  0, 1, 1});
    tv.push_back('{1, 90,  0, 0, 0,   0, 1, 90, 0, 0});
    tv.push_back('{0, 0,   1, 1, 9,   1, 0, 99, 0, 0});
    tv.push_back('{0, 0,   1, 1, 1,   1, 0, 99, 1, 1});
    foreach (tv[i]) begin
      set_in(tv[i].ld, tv[i].dv, tv[i].e, tv[i].u, tv[i].st, tv[i].sa, tv[i].cl);
      cycle();
      check_all($sformatf("vec%0d", i), tv[i].eq, tv[i].etc, tv[i].eo);
    end
`else
    // Prime ovf so the async-reset check below has something to clear
    set_in(1, 99, 0, 0, 0, 0, 0);
    cycle();
    set_in(0, 0, 1, 1, 1, 0, 0);
    repeat (PS) cycle();
    check_all("prime", 0, 1, 1);
`endif

    // Async reset mid-cycle with ovf set and a count in progress
    set_in(1, 40, 0, 0, 0, 0, 0);
    cycle();
    set_in(0, 0, 1, 1, 1, 0, 0);
    repeat (2 * PS) cycle();
    check("pre_reset.q", int'(q), 42);
    check("pre_reset.ovf", int'(ovf), 1);
    #3;
    reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 0);
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all("reset_hold", 0, 0, 0);
    end
    reset = 1'b0;

    // First update after release, and prescale spacing
    set_in(0, 0, 1, 1, 1, 0, 0);
    for (int unsigned k = 1; k <= PS; k++) begin
      cycle();
      check("ps_first.q", int'(q), (k == PS) ? 1 : 0);
    end
    repeat (PS) cycle();
    check("ps_second.q", int'(q), 2);

    // Random stimulus against the model
    for (int unsigned n = 0; n < 600; n++) begin
      set_in(($urandom_range(0, 15) == 0) ? 1 : 0,
             int'($urandom_range(0, 127)),
             ($urandom_range(0, 3) != 0) ? 1 : 0,
             int'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(90, 127))
                                         : int'($urandom_range(0, 12)),
             int'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0) ? 1 : 0);
      cycle();
      check_all("rand", mq, mtc, movf);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
